small_poly_serializer: RTL and testbench

Reads one small polynomial from the coefficient RAM filled by the CBD small-polynomial generator and streams its 256 coefficients out in natural order (0..255), one per `out_valid`/`out_ready` handshake. The generator stores eight 12-bit coefficients per 96-bit word in interleaved order. This block undoes that interleaving for the downstream serial consumers (encode/compress, hashing, debug capture). It sits between the coefficient RAM read port and those consumers.

---
 rtl/small_poly_serializer.sv | 175 +++++++++++++++++
 tb/tb_small_poly_serializer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/small_poly_serializer.sv
// small_poly_serializer
// Reads one 256-coefficient polynomial (32 words of eight 12-bit lanes, stored
// interleaved by the CBD generator) and streams it out in natural order 0..255
// over a valid/ready handshake. Each word is read four times; read n yields
// coefficients 2n and 2n+1. One read is kept in flight ahead of the output.
// Optional build macro: POLY_SER_RANGE_CHECK_EN enables the sticky range_err
// flag (coefficient >= Q seen on a handshake). Without it range_err is 0.
module small_poly_serializer #(
   parameter int COEFF_W = 12,
   parameter int Q       = 3329
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [7:0]           ram_r_start_offset,
   output logic                 ren,
   output logic [7:0]           raddr,
   input  logic [8*COEFF_W-1:0] rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [COEFF_W-1:0]   out_coeff,
   output logic [7:0]           out_idx,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done,
   output logic                 range_err
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_FILL, S_EMIT0, S_EMIT1} state_t;

   if (Q >= (1 << COEFF_W)) begin : g_q_check
      $error("Q must be representable in COEFF_W bits");
   end

   state_t                 state;
   logic [7:0]             offset;
   logic [7:0]             rd_cnt;     // reads issued so far, 0..128
   logic [6:0]             pair_n;     // index of the pair held in pair
   logic                   rd_pend;
   logic [1:0]             rd_q;
   logic                   stage_v;
   logic [2*COEFF_W-1:0]   pair;
   logic [2*COEFF_W-1:0]   stage;
   logic [2*COEFF_W-1:0]   lane_pair;
   logic [2*COEFF_W-1:0]   stage_nxt;
   logic                   hs;
   logic                   last_pair;

   // Quarter q of the polynomial lives in lane pair (0,1),(4,5),(2,3),(6,7)
   function automatic logic [2*COEFF_W-1:0] sel_pair(input logic [8*COEFF_W-1:0] d,
                                                     input logic [1:0] q);
      logic [2*COEFF_W-1:0] r;
      case (q)
         2'd0:    r = d[0*COEFF_W +: 2*COEFF_W];
         2'd1:    r = d[4*COEFF_W +: 2*COEFF_W];
         2'd2:    r = d[2*COEFF_W +: 2*COEFF_W];
         default: r = d[6*COEFF_W +: 2*COEFF_W];
      endcase
      return r;
   endfunction

   // Output decode and the pair that follows the current one; a read landing in
   // the same cycle as the EMIT1 handshake is forwarded straight from rdata
   always_comb begin
      lane_pair = sel_pair(rdata, rd_q);
      stage_nxt = stage_v ? stage : lane_pair;
      out_valid = (state == S_EMIT0) || (state == S_EMIT1);
      hs        = out_valid && out_ready;
      last_pair = (pair_n == 7'd127);
      busy      = (state != S_IDLE);
      out_coeff = '0;
      out_idx   = '0;
      out_last  = 1'b0;
      if (state == S_EMIT0) begin
         out_coeff = pair[COEFF_W-1:0];
         out_idx   = {pair_n, 1'b0};
      end else if (state == S_EMIT1) begin
         out_coeff = pair[2*COEFF_W-1:COEFF_W];
         out_idx   = {pair_n, 1'b1};
         out_last  = last_pair;
      end
   end

   // Control FSM: read issue, prefetch bookkeeping and handshake sequencing
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         offset  <= '0;
         rd_cnt  <= '0;
         pair_n  <= '0;
         rd_pend <= 1'b0;
         rd_q    <= '0;
         stage_v <= 1'b0;
         ren     <= 1'b0;
         raddr   <= '0;
         done    <= 1'b0;
      end else begin
         ren     <= 1'b0;
         done    <= 1'b0;
         rd_pend <= ren;
         if (rd_pend) stage_v <= 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  offset  <= ram_r_start_offset;
                  pair_n  <= '0;
                  stage_v <= 1'b0;
                  ren     <= 1'b1;
                  raddr   <= ram_r_start_offset;
                  rd_q    <= 2'd0;
                  rd_cnt  <= 8'd1;
                  state   <= S_RD;
               end
            end
            S_RD: begin
               ren    <= 1'b1;
               raddr  <= offset + {3'b000, rd_cnt[4:0]};
               rd_q   <= rd_cnt[6:5];
               rd_cnt <= rd_cnt + 8'd1;
               state  <= S_FILL;
            end
            S_FILL: begin
               // read 0 goes straight into pair, not into the prefetch slot
               stage_v <= 1'b0;
               state   <= S_EMIT0;
            end
            S_EMIT0: begin
               if (hs) state <= S_EMIT1;
            end
            S_EMIT1: begin
               if (hs) begin
                  if (last_pair) begin
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     pair_n  <= pair_n + 7'd1;
                     stage_v <= 1'b0;
                     if (!rd_cnt[7]) begin
                        ren    <= 1'b1;
                        raddr  <= offset + {3'b000, rd_cnt[4:0]};
                        rd_q   <= rd_cnt[6:5];
                        rd_cnt <= rd_cnt + 8'd1;
                     end
                     state <= S_EMIT0;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Coefficient datapath: prefetch slot capture and current pair load
   always_ff @(posedge clk) begin
      if (rd_pend) stage <= lane_pair;
      if (state == S_FILL) pair <= lane_pair;
      else if ((state == S_EMIT1) && hs && !last_pair) pair <= stage_nxt;
   end

`ifdef POLY_SER_RANGE_CHECK_EN
   // Sticky out-of-range flag, cleared by an accepted start
   always_ff @(posedge clk) begin
      if (rst) begin
         range_err <= 1'b0;
      end else if ((state == S_IDLE) && start) begin
         range_err <= 1'b0;
      end else if (hs && (out_coeff >= COEFF_W'(Q))) begin
         range_err <= 1'b1;
      end
   end
`else
   assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_small_poly_serializer.sv
// Testbench for small_poly_serializer: RAM model with one-cycle read latency,
// a reference polynomial array packed into words by the documented lane layout,
// and a per-cycle compare process that follows the expected output stream.
module tb_small_poly_serializer;

`ifdef POLY_SER_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  ram_r_start_offset = '0;
   logic        ren;
   logic [7:0]  raddr;
   logic [95:0] rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [11:0] out_coeff;
   logic [7:0]  out_idx;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        range_err;

   small_poly_serializer dut (
      .clk(clk), .rst(rst), .start(start), .ram_r_start_offset(ram_r_start_offset),
      .ren(ren), .raddr(raddr), .rdata(rdata), .out_valid(out_valid),
      .out_ready(out_ready), .out_coeff(out_coeff), .out_idx(out_idx),
      .out_last(out_last), .busy(busy), .done(done), .range_err(range_err)
   );

   always #5 clk = ~clk;

   logic [95:0] mem [256];
   logic [11:0] poly_ref [256];

   int   n_checks = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;
   int   rdy_mode = 0;
   int   exp_idx = 0;
   int   ren_cnt = 0;
   logic [7:0]  off_m = '0;
   logic        exp_rerr = 1'b0;
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic [11:0] prev_coeff = '0;
   logic [7:0]  prev_idx = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // RAM read port model
   always @(posedge clk) if (ren) rdata <= mem[raddr];

   // Consumer ready: held high or pseudo-random
   always @(posedge clk) begin
      #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
   end

   task automatic ident_poly();
      for (int c = 0; c < 256; c++) poly_ref[c] = 12'(c);
   endtask

   task automatic rand_poly();
      for (int c = 0; c < 256; c++) poly_ref[c] = 12'($urandom_range(0, 4095));
   endtask

   task automatic fill(input logic [7:0] off);
      logic [7:0] a;
      for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
      for (int k = 0; k < 32; k++) begin
         a = off + 8'(k);
         mem[a] = {poly_ref[2*k+193], poly_ref[2*k+192], poly_ref[2*k+65], poly_ref[2*k+64],
                   poly_ref[2*k+129], poly_ref[2*k+128], poly_ref[2*k+1], poly_ref[2*k]};
      end
   endtask

   task automatic do_start(input logic [7:0] off);
      @(posedge clk); #1;
      ram_r_start_offset = off;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      chk("done_timeout", got, 1);
   endtask

   task automatic wait_idx(input int n, input int budget);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (exp_idx >= n) got = 1'b1;
      end
      chk("idx_timeout", got, 1);
   endtask

   // Per-cycle compare against the expected natural-order stream
   always @(negedge clk) begin
      if (chk_en) begin
         if (rst) begin
            exp_idx = 0;
            ren_cnt = 0;
            exp_rerr = 1'b0;
            prev_valid = 1'b0;
         end else begin
            chk("range_err", range_err, exp_rerr);
            if (prev_valid && !prev_ready) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_coeff", out_coeff, prev_coeff);
               chk("stall_idx", out_idx, prev_idx);
            end
            if (out_valid) begin
               chk("out_coeff", out_coeff, poly_ref[exp_idx & 255]);
               chk("out_idx", out_idx, exp_idx);
               chk("out_last", out_last, exp_idx == 255);
               if (out_ready) begin
                  if (RC && out_coeff >= 12'd3329) exp_rerr = 1'b1;
                  exp_idx++;
               end
            end else begin
               chk("idle_coeff", out_coeff, 0);
               chk("idle_idx", out_idx, 0);
               chk("idle_last", out_last, 0);
            end
            if (ren) begin
               chk("ren_extra", ren_cnt < 128, 1);
               chk("raddr", raddr, 8'(off_m + 8'(ren_cnt % 32)));
               ren_cnt++;
            end
            if (done) begin
               chk("done_count", exp_idx, 256);
               chk("done_reads", ren_cnt, 128);
               chk("done_busy", busy, 0);
            end
            if (start && !busy) begin
               exp_idx = 0;
               ren_cnt = 0;
               off_m = ram_r_start_offset;
               exp_rerr = 1'b0;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_coeff = out_coeff;
            prev_idx = out_idx;
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      ident_poly();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ren", ren, 0);
      chk("rst_raddr", raddr, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_coeff", out_coeff, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_range", range_err, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;

      // Identity data, offset 0x20, ready held high: cycle-exact timing
      ident_poly();
      fill(8'h20);
      rdy_mode = 0;
      do_start(8'h20);
      for (int c = 1; c <= 260; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("c1_ren", ren, 1);
            chk("c1_raddr", raddr, 8'h20);
            chk("c1_busy", busy, 1);
         end
         if (c == 2) chk("c2_valid", out_valid, 0);
         if (c == 3) begin
            chk("c3_valid", out_valid, 1);
            chk("c3_coeff", out_coeff, 0);
         end
         if (c == 4) chk("c4_coeff", out_coeff, 1);
         if (c == 257) chk("c257_last", out_last, 0);
         if (c == 258) begin
            chk("c258_coeff", out_coeff, 255);
            chk("c258_last", out_last, 1);
         end
         if (c == 259) begin
            chk("c259_done", done, 1);
            chk("c259_busy", busy, 0);
         end
      end

      // Random data, random backpressure
      rand_poly();
      fill(8'h20);
      rdy_mode = 1;
      do_start(8'h20);
      wait_done(3000);

      // Address wrap at offset 0xF0
      rand_poly();
      fill(8'hF0);
      rdy_mode = 0;
      do_start(8'hF0);
      @(negedge clk);
      chk("wrap_raddr0", raddr, 8'hF0);
      wait_done(600);

      // A second start mid-stream is ignored
      rand_poly();
      fill(8'h5C);
      rdy_mode = 1;
      do_start(8'h5C);
      wait_idx(100, 2000);
      @(posedge clk); #1;
      ram_r_start_offset = 8'h00;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(3000);

      // Reset mid-stream, then restart from coefficient 0
      rdy_mode = 0;
      do_start(8'h5C);
      wait_idx(50, 600);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_valid", out_valid, 0);
      chk("abort_coeff", out_coeff, 0);
      chk("abort_ren", ren, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      rdy_mode = 1;
      do_start(8'h5C);
      wait_done(3000);

      // Out-of-range coefficient 70 (word 3 lane 4)
      ident_poly();
      poly_ref[70] = 12'd3329;
      fill(8'h10);
      rdy_mode = 0;
      do_start(8'h10);
      wait_done(600);
      repeat (3) @(negedge clk);
      chk("range_sticky", range_err, RC);

      // Next start clears the flag
      rand_poly();
      fill(8'hA7);
      rdy_mode = 1;
      do_start(8'hA7);
      @(negedge clk);
      chk("range_clear", range_err, 0);
      wait_done(3000);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
